// File: rtl/mac_pkg.sv
// Shared MAC definitions: TX framer states, CRC-32 constants and the byte-wide
// reflected CRC-32 update used by both the TX framer and the RX checker.
package mac_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_DATA = 3'd2,
    S_PAD  = 3'd3,
    S_FCS  = 3'd4,
    S_IFG  = 3'd5
  } tx_state_e;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;
  localparam logic [63:0] PREAMBLE_SFD  = 64'h5555_5555_5555_55D5;

  // IEEE 802.3 CRC-32, reflected form: one byte folded in LSB first
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h00_0000, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) begin
        c = (c >> 1) ^ CRC32_POLY;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/mac_crc32_d8.sv
// Registered byte-wide CRC-32 accumulator; init wins over enable.
// crc_out is the raw register, the caller inverts it to form the FCS.
module mac_crc32_d8
  import mac_pkg::*;
(
  input  logic        clk,
  input  logic        logic_rst,
  input  logic        init,
  input  logic        enable,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  // CRC register: re-seeded on init, advanced by one byte on enable
  always_ff @(posedge clk or posedge logic_rst) begin
    if (logic_rst) begin
      crc_out <= CRC32_INIT;
    end else if (init) begin
      crc_out <= CRC32_INIT;
    end else if (enable) begin
      crc_out <= crc32_byte(crc_out, data);
    end else begin
      crc_out <= crc_out;
    end
  end

endmodule

// File: rtl/mac_tx_crc_append.sv
// MAC transmit framer: AXI-stream bytes in, GMII bytes out with preamble/SFD,
// zero padding to MIN_FRAME, appended FCS and a forced inter-frame gap.
module mac_tx_crc_append
  import mac_pkg::*;
#(
  parameter int          MIN_FRAME = 32'd60,
  parameter int          IFG_BYTES = 32'd12,
  parameter logic [63:0] PREAMBLE  = PREAMBLE_SFD
) (
  input  logic       clk,
  input  logic       logic_rst,
  input  logic [7:0] mac_data_in,
  input  logic       mac_valid_in,
  output logic       mac_ready_out,
  input  logic       mac_last_in,
  input  logic       mac_user_in,
  output logic [7:0] phy_txd_out,
  output logic       phy_tvalid_out,
  output logic       phy_terr_out
);

  tx_state_e   state_r;
  logic [15:0] phase_cnt_r;
  logic [15:0] byte_cnt_r;
  logic        err_r;
  logic        ready_r;
  logic [7:0]  txd_r;
  logic        tvalid_r;
  logic        terr_r;

  logic        crc_init_s;
  logic        crc_en_s;
  logic [7:0]  crc_data_s;
  logic [31:0] crc_s;
  logic [31:0] fcs_s;
  logic [15:0] cnt_inc_s;
  logic        need_pad_s;
  logic        ifg_done_s;
  logic [7:0]  pre_byte_s;
  logic [7:0]  fcs_byte_s;

  assign mac_ready_out  = ready_r;
  assign phy_txd_out    = txd_r;
  assign phy_tvalid_out = tvalid_r;
  assign phy_terr_out   = terr_r;

  assign fcs_s      = ~crc_s;
  assign crc_init_s = (state_r == S_PRE);
  assign cnt_inc_s  = (byte_cnt_r == 16'hFFFF) ? byte_cnt_r : byte_cnt_r + 16'd1;
  // Decided on the count after the current byte, both for the last data byte and each pad byte
  assign need_pad_s = int'({16'h0000, cnt_inc_s}) < MIN_FRAME;
  assign ifg_done_s = int'({16'h0000, phase_cnt_r}) >= (IFG_BYTES - 32'd1);

  // CRC feed: accepted payload bytes and pad zeros only, never the preamble
  always_comb begin
    crc_en_s   = 1'b0;
    crc_data_s = 8'h00;
    case (state_r)
      S_DATA: begin
        crc_en_s   = mac_valid_in;
        crc_data_s = mac_data_in;
      end
      S_PAD: begin
        crc_en_s   = 1'b1;
        crc_data_s = 8'h00;
      end
      default: begin
        crc_en_s   = 1'b0;
        crc_data_s = 8'h00;
      end
    endcase
  end

  // Preamble byte selection, most significant byte first
  always_comb begin
    pre_byte_s = 8'h00;
    case (phase_cnt_r[2:0])
      3'd0:    pre_byte_s = PREAMBLE[63:56];
      3'd1:    pre_byte_s = PREAMBLE[55:48];
      3'd2:    pre_byte_s = PREAMBLE[47:40];
      3'd3:    pre_byte_s = PREAMBLE[39:32];
      3'd4:    pre_byte_s = PREAMBLE[31:24];
      3'd5:    pre_byte_s = PREAMBLE[23:16];
      3'd6:    pre_byte_s = PREAMBLE[15:8];
      3'd7:    pre_byte_s = PREAMBLE[7:0];
      default: pre_byte_s = 8'h00;
    endcase
  end

  // FCS byte selection, least significant byte first
  always_comb begin
    fcs_byte_s = 8'h00;
    case (phase_cnt_r[1:0])
      2'd0:    fcs_byte_s = fcs_s[7:0];
      2'd1:    fcs_byte_s = fcs_s[15:8];
      2'd2:    fcs_byte_s = fcs_s[23:16];
      2'd3:    fcs_byte_s = fcs_s[31:24];
      default: fcs_byte_s = 8'h00;
    endcase
  end

  mac_crc32_d8 u_crc (
    .clk       (clk),
    .logic_rst (logic_rst),
    .init      (crc_init_s),
    .enable    (crc_en_s),
    .data      (crc_data_s),
    .crc_out   (crc_s)
  );

  // Framing FSM with registered PHY outputs and ready
  always_ff @(posedge clk or posedge logic_rst) begin
    if (logic_rst) begin
      state_r     <= S_IDLE;
      phase_cnt_r <= 16'd0;
      byte_cnt_r  <= 16'd0;
      err_r       <= 1'b0;
      ready_r     <= 1'b0;
      txd_r       <= 8'h00;
      tvalid_r    <= 1'b0;
      terr_r      <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          terr_r  <= 1'b0;
          ready_r <= 1'b0;
          // Start of frame is only observed here; the byte is taken later in S_DATA
          if (mac_valid_in) begin
            state_r     <= S_PRE;
            txd_r       <= PREAMBLE[63:56];
            tvalid_r    <= 1'b1;
            phase_cnt_r <= 16'd1;
          end else begin
            txd_r    <= 8'h00;
            tvalid_r <= 1'b0;
          end
        end
        S_PRE: begin
          txd_r    <= pre_byte_s;
          tvalid_r <= 1'b1;
          terr_r   <= 1'b0;
          if (phase_cnt_r == 16'd7) begin
            state_r     <= S_DATA;
            ready_r     <= 1'b1;
            phase_cnt_r <= 16'd0;
          end else begin
            phase_cnt_r <= phase_cnt_r + 16'd1;
          end
        end
        S_DATA: begin
          tvalid_r <= 1'b1;
          if (mac_valid_in) begin
            txd_r      <= mac_data_in;
            terr_r     <= mac_user_in;
            err_r      <= err_r | mac_user_in;
            byte_cnt_r <= cnt_inc_s;
            if (mac_last_in) begin
              ready_r <= 1'b0;
              state_r <= need_pad_s ? S_PAD : S_FCS;
            end
          end else begin
            // Underrun: the frame keeps going on the wire but is marked bad
            txd_r  <= 8'h00;
            terr_r <= 1'b1;
            err_r  <= 1'b1;
          end
        end
        S_PAD: begin
          txd_r      <= 8'h00;
          tvalid_r   <= 1'b1;
          terr_r     <= 1'b0;
          byte_cnt_r <= cnt_inc_s;
          if (!need_pad_s) begin
            state_r <= S_FCS;
          end
        end
        S_FCS: begin
          txd_r    <= fcs_byte_s;
          tvalid_r <= 1'b1;
          terr_r   <= err_r;
          if (phase_cnt_r[1:0] == 2'd3) begin
            state_r     <= (IFG_BYTES == 32'd0) ? S_IDLE : S_IFG;
            phase_cnt_r <= 16'd0;
            err_r       <= 1'b0;
            byte_cnt_r  <= 16'd0;
          end else begin
            phase_cnt_r <= phase_cnt_r + 16'd1;
          end
        end
        S_IFG: begin
          txd_r      <= 8'h00;
          tvalid_r   <= 1'b0;
          terr_r     <= 1'b0;
          err_r      <= 1'b0;
          byte_cnt_r <= 16'd0;
          if (ifg_done_s) begin
            state_r     <= S_IDLE;
            phase_cnt_r <= 16'd0;
          end else begin
            phase_cnt_r <= phase_cnt_r + 16'd1;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          phase_cnt_r <= 16'd0;
          byte_cnt_r  <= 16'd0;
          err_r       <= 1'b0;
          ready_r     <= 1'b0;
          txd_r       <= 8'h00;
          tvalid_r    <= 1'b0;
          terr_r      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_tx_crc_append.sv
// Scoreboard bench for mac_tx_crc_append: a frame-level model queues expected
// wire beats and frame info; a negedge monitor pops and compares.
module tb_mac_tx_crc_append;

  localparam int MIN_FRAME = 60;
  localparam int IFG       = 12;
  localparam logic [31:0] RESIDUE = 32'hDEBB_20E3;

  logic       clk = 1'b0;
  logic       logic_rst;
  logic [7:0] mac_data_in;
  logic       mac_valid_in;
  logic       mac_ready_out;
  logic       mac_last_in;
  logic       mac_user_in;
  logic [7:0] phy_txd_out;
  logic       phy_tvalid_out;
  logic       phy_terr_out;

  always #4 clk = ~clk;

  mac_tx_crc_append #(
    .MIN_FRAME (MIN_FRAME),
    .IFG_BYTES (IFG),
    .PREAMBLE  (64'h5555_5555_5555_55D5)
  ) dut (
    .clk            (clk),
    .logic_rst      (logic_rst),
    .mac_data_in    (mac_data_in),
    .mac_valid_in   (mac_valid_in),
    .mac_ready_out  (mac_ready_out),
    .mac_last_in    (mac_last_in),
    .mac_user_in    (mac_user_in),
    .phy_txd_out    (phy_txd_out),
    .phy_tvalid_out (phy_tvalid_out),
    .phy_terr_out   (phy_terr_out)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       er;
  } beat_t;

  typedef struct packed {
    int   len;
    logic exact;
    logic chk_res;
  } info_t;

  beat_t      exp_q[$];
  info_t      info_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic       ignore_mon = 1'b0;
  logic [7:0] rx_bytes[$];
  int         beat_cnt = 0;
  int         idle_cnt = 1000;
  bit         in_frame = 1'b0;
  beat_t      mb;
  info_t      mi;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  // Bit-serial CRC-32 straight from the polynomial definition; returns the FCS value
  function automatic logic [31:0] ref_fcs(input logic [7:0] d[$]);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    foreach (d[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ d[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    end
    return ~c;
  endfunction

  // Monitor: compare every wire beat, frame length, gap and CRC residue
  always @(negedge clk) begin
    if (logic_rst || ignore_mon) begin
      in_frame = 1'b0;
      exp_q.delete();
      info_q.delete();
      rx_bytes.delete();
      idle_cnt = 1000;
    end else if (phy_tvalid_out) begin
      if (!in_frame) begin
        in_frame = 1'b1;
        beat_cnt = 0;
        rx_bytes.delete();
        if (info_q.size() == 0) fail_now("frame_unexpected");
        else if (info_q[0].exact) check("ifg_exact", 32'(idle_cnt), 32'(IFG));
        else begin
          n_cmp++;
          if (idle_cnt < IFG) begin
            n_bad++;
            $display("FAIL ifg_min: got %0d want >= %0d", idle_cnt, IFG);
          end
        end
      end
      beat_cnt++;
      rx_bytes.push_back(phy_txd_out);
      if (exp_q.size() == 0) fail_now("beat_unexpected");
      else begin
        mb = exp_q.pop_front();
        check("txd", 32'(phy_txd_out), 32'(mb.d));
        check("terr", 32'(phy_terr_out), 32'(mb.er));
      end
    end else begin
      check("idle_out", 32'({phy_txd_out, phy_terr_out}), 32'h0);
      if (in_frame) begin
        in_frame = 1'b0;
        idle_cnt = 1;
        if (info_q.size() != 0) begin
          mi = info_q.pop_front();
          check("frame_len", 32'(beat_cnt), 32'(mi.len));
          if (mi.chk_res && rx_bytes.size() > 8)
            check("residue", ~ref_fcs(rx_bytes[8:$]), RESIDUE);
        end
      end else begin
        idle_cnt++;
      end
    end
  end

  // Model the whole wire image of one frame, then drive it byte by byte
  task automatic send_frame(input logic [7:0] d[$], input int user_idx,
                            input int ur_pos, input int ur_len, input bit b2b);
    logic [7:0]  crcb[$];
    logic [31:0] fcs;
    bit          err;
    info_t       inf;
    int          t;
    err = (user_idx >= 0) || (ur_len > 0);
    for (int k = 0; k < 7; k++) exp_q.push_back({8'h55, 1'b0});
    exp_q.push_back({8'hD5, 1'b0});
    for (int i = 0; i < d.size(); i++) begin
      if (i == ur_pos && ur_len > 0)
        for (int k = 0; k < ur_len; k++) exp_q.push_back({8'h00, 1'b1});
      exp_q.push_back({d[i], 1'(i == user_idx)});
      crcb.push_back(d[i]);
    end
    while (crcb.size() < MIN_FRAME) begin
      crcb.push_back(8'h00);
      exp_q.push_back({8'h00, 1'b0});
    end
    fcs = ref_fcs(crcb);
    for (int k = 0; k < 4; k++) exp_q.push_back({fcs[8*k +: 8], err});
    inf.len     = 8 + crcb.size() + ur_len + 4;
    inf.exact   = b2b;
    inf.chk_res = (ur_len == 0);
    info_q.push_back(inf);

    for (int i = 0; i < d.size(); i++) begin
      if (i == ur_pos && ur_len > 0) begin
        mac_valid_in = 1'b0;
        repeat (ur_len) @(posedge clk);
        #1;
      end
      mac_data_in  = d[i];
      mac_last_in  = (i == d.size() - 1);
      mac_user_in  = (i == user_idx);
      mac_valid_in = 1'b1;
      t = 0;
      while (!mac_ready_out && t < 300) begin
        @(posedge clk);
        #1;
        t++;
      end
      if (!mac_ready_out) begin
        fail_now("ready_timeout");
        mac_valid_in = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    mac_last_in = 1'b0;
    mac_user_in = 1'b0;
  endtask

  task automatic idle(input int n);
    mac_valid_in = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rand_bytes(input int n, output logic [7:0] q[$]);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || in_frame) && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0 || in_frame) fail_now("drain_timeout");
    #1;
  endtask

  initial begin
    logic [7:0] q[$];
    int         n, uidx, upos, ulen, t;
    bit         b2b;
    logic_rst    = 1'b1;
    mac_data_in  = 8'h00;
    mac_valid_in = 1'b0;
    mac_last_in  = 1'b0;
    mac_user_in  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_txd", 32'(phy_txd_out), 32'h0);
    check("rst_tvalid", 32'(phy_tvalid_out), 32'h0);
    check("rst_terr", 32'(phy_terr_out), 32'h0);
    check("rst_ready", 32'(mac_ready_out), 32'h0);
    logic_rst = 1'b0;
    @(posedge clk);
    #1;

    // Short frame: padding to minimum length
    rand_bytes(14, q);
    send_frame(q, -1, -1, 0, 1'b0);
    idle(5);
    // Underrun of two cycles mid-payload, then a clean frame
    rand_bytes(30, q);
    send_frame(q, -1, 10, 2, 1'b0);
    idle(3);
    rand_bytes(20, q);
    send_frame(q, -1, -1, 0, 1'b0);
    idle(2);
    // Three 72-byte frames with valid held high throughout
    for (int k = 0; k < 3; k++) begin
      rand_bytes(72, q);
      send_frame(q, -1, -1, 0, k != 0);
    end
    idle(4);
    // Aborted frame flagged via user
    rand_bytes(40, q);
    send_frame(q, 5, -1, 0, 1'b0);
    idle(1);

    for (int f = 0; f < 25; f++) begin
      n    = int'($urandom_range(1, 100));
      uidx = ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      upos = -1;
      ulen = 0;
      if (n >= 2 && $urandom_range(0, 4) == 0) begin
        upos = int'($urandom_range(1, n - 1));
        ulen = int'($urandom_range(1, 3));
      end
      b2b = ($urandom_range(0, 2) == 0) && (f != 0);
      if (!b2b) idle(int'($urandom_range(0, 20)));
      rand_bytes(n, q);
      send_frame(q, uidx, upos, ulen, b2b);
    end
    idle(1);
    drain();

    // Reset in the middle of the payload
    ignore_mon   = 1'b1;
    mac_data_in  = 8'hA5;
    mac_last_in  = 1'b0;
    mac_valid_in = 1'b1;
    t = 0;
    while (!mac_ready_out && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (20) @(posedge clk);
    #1;
    check("pre_rst_tvalid", 32'(phy_tvalid_out), 32'h1);
    logic_rst    = 1'b1;
    mac_valid_in = 1'b0;
    #1;
    check("mid_rst_txd", 32'(phy_txd_out), 32'h0);
    check("mid_rst_tvalid", 32'(phy_tvalid_out), 32'h0);
    check("mid_rst_terr", 32'(phy_terr_out), 32'h0);
    check("mid_rst_ready", 32'(mac_ready_out), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    logic_rst  = 1'b0;
    ignore_mon = 1'b0;
    @(posedge clk);
    #1;
    rand_bytes(50, q);
    send_frame(q, -1, -1, 0, 1'b0);
    idle(1);
    drain();
    repeat (IFG + 2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
